// File: rtl/fib_term_controller.sv
// -----------------------------------------------------------------------------
// fib_term_controller
//
// Request/response sequencer around a Fibonacci datapath (F(0)=0, F(1)=1).
// A term index is accepted over a valid/ready handshake. The internal pair
// (a,b) = (F(k),F(k+1)) then steps forward one term per cycle (single rate)
// or two terms per cycle (double rate). The controller returns
// F(idx) mod 2^WIDTH together with a sticky overflow flag. Nothing runs while
// the controller is idle, so several upstream users can share one generator.
//
// Ports:
//   clk          in   system clock, all state updates on the rising edge
//   rst          in   asynchronous active-low reset
//   req_valid    in   request present
//   req_ready    out  controller can accept a request (IDLE only)
//   req_idx      in   requested term index, sampled at the accepting edge
//   req_double   in   1 = double-rate stepping, 0 = single-rate
//   rsp_valid    out  result available (DONE)
//   rsp_ready    in   consumer accepts the result
//   rsp_value    out  F(idx) mod 2^WIDTH
//   rsp_overflow out  true F(idx) >= 2^WIDTH
//   busy         out  controller is in CALC or DONE
// -----------------------------------------------------------------------------
module fib_term_controller #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [IDX_W-1:0] req_idx,
  input  logic             req_double,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_value,
  output logic             rsp_overflow,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IDX_W-1:0] REM_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] REM_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] REM_TWO  = IDX_W'(2'd2);

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [IDX_W-1:0] rem_r, rem_s;
  logic             mode_r, mode_s;
  logic             ovf_a_r, ovf_a_s;
  logic             ovf_b_r, ovf_b_s;

  logic [WIDTH:0]   sum1_s;     // a + b with carry out
  logic [WIDTH+1:0] sum2_s;     // a + 2b with two guard bits
  logic             dbl_step_s;
  logic [IDX_W-1:0] step_s;

  // Adders shared by both step kinds; the guard bits carry the overflow info.
  always_comb begin
    sum1_s = {1'b0, a_r} + {1'b0, b_r};
    sum2_s = {2'b00, a_r} + {1'b0, b_r, 1'b0};
  end

  // Double stepping only while at least two terms remain; the odd last term
  // of a double-rate request falls back to a single step.
  always_comb begin
    if (mode_r && (rem_r >= REM_TWO)) begin
      dbl_step_s = 1'b1;
      step_s     = REM_TWO;
    end else begin
      dbl_step_s = 1'b0;
      step_s     = REM_ONE;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    rem_s   = rem_r;
    mode_s  = mode_r;
    ovf_a_s = ovf_a_r;
    ovf_b_s = ovf_b_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          a_s     = {WIDTH{1'b0}};
          b_s     = WIDTH'(1'b1);
          ovf_a_s = 1'b0;
          ovf_b_s = 1'b0;
          rem_s   = req_idx;
          mode_s  = req_double;
          if (req_idx != REM_ZERO) begin
            state_s = ST_CALC;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (dbl_step_s) begin
          a_s     = sum1_s[WIDTH-1:0];
          b_s     = sum2_s[WIDTH-1:0];
          ovf_a_s = ovf_a_r | ovf_b_r | sum1_s[WIDTH];
          ovf_b_s = ovf_a_r | ovf_b_r | (|sum2_s[WIDTH+1:WIDTH]);
        end else begin
          a_s     = b_r;
          b_s     = sum1_s[WIDTH-1:0];
          ovf_a_s = ovf_b_r;
          ovf_b_s = ovf_a_r | ovf_b_r | sum1_s[WIDTH];
        end
        rem_s = rem_r - step_s;
        // The step that exhausts the count moves to DONE on the same edge.
        if (rem_r == step_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= WIDTH'(1'b1);
      rem_r   <= REM_ZERO;
      mode_r  <= 1'b0;
      ovf_a_r <= 1'b0;
      ovf_b_r <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      rem_r   <= rem_s;
      mode_r  <= mode_s;
      ovf_a_r <= ovf_a_s;
      ovf_b_r <= ovf_b_s;
    end
  end

  // Outputs are pure decodes of registers; the result is zero outside DONE.
  always_comb begin
    req_ready = (state_r == ST_IDLE);
    busy      = (state_r != ST_IDLE);
    rsp_valid = (state_r == ST_DONE);
    if (state_r == ST_DONE) begin
      rsp_value    = a_r;
      rsp_overflow = ovf_a_r;
    end else begin
      rsp_value    = {WIDTH{1'b0}};
      rsp_overflow = 1'b0;
    end
  end

endmodule

// File: tb/tb_fib_term_controller.sv
module tb_fib_term_controller;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_idx;
  logic        req_double;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_value;
  logic        rsp_overflow;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [5:0]  idx;
    logic        dbl;
    logic [15:0] val;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  fib_term_controller #(.WIDTH(16), .IDX_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_idx      (req_idx),
    .req_double   (req_double),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_value    (rsp_value),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Present one request at a negedge, measure latency, check result, drain it.
  task automatic run_vec(input logic [5:0] idx, input logic dbl,
                         input logic [15:0] val, input logic ovf, input int lat);
    int cnt;
    logic bad;
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_idx    = idx;
    req_double = dbl;
    rsp_ready  = 1'b0;
    @(negedge clk);
    req_valid  = 1'b0;
    req_idx    = 6'd0;
    req_double = 1'b0;
    cnt = 0;
    bad = 1'b0;
    while (!rsp_valid && cnt < 200) begin
      if (req_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
      cnt++;
    end
    check($sformatf("latency_idx%0d_d%0d", idx, dbl), cnt, lat);
    check("calc_handshake", {31'd0, bad}, 32'd0);
    check($sformatf("value_idx%0d_d%0d", idx, dbl), {16'd0, rsp_value}, {16'd0, val});
    check($sformatf("ovf_idx%0d_d%0d", idx, dbl), {31'd0, rsp_overflow}, {31'd0, ovf});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    int cnt;
    logic bad;

    vecs[0]  = '{6'd10, 1'b0, 16'd55,    1'b0, 10};
    vecs[1]  = '{6'd10, 1'b1, 16'd55,    1'b0, 5};
    vecs[2]  = '{6'd7,  1'b1, 16'd13,    1'b0, 4};
    vecs[3]  = '{6'd0,  1'b0, 16'd0,     1'b0, 0};
    vecs[4]  = '{6'd0,  1'b1, 16'd0,     1'b0, 0};
    vecs[5]  = '{6'd1,  1'b0, 16'd1,     1'b0, 1};
    vecs[6]  = '{6'd1,  1'b1, 16'd1,     1'b0, 1};
    vecs[7]  = '{6'd24, 1'b0, 16'd46368, 1'b0, 24};
    vecs[8]  = '{6'd25, 1'b0, 16'd9489,  1'b1, 25};
    vecs[9]  = '{6'd25, 1'b1, 16'd9489,  1'b1, 13};
    vecs[10] = '{6'd63, 1'b0, 16'd25826, 1'b1, 63};
    vecs[11] = '{6'd63, 1'b1, 16'd25826, 1'b1, 32};
    vecs[12] = '{6'd2,  1'b1, 16'd1,     1'b0, 1};
    vecs[13] = '{6'd3,  1'b1, 16'd2,     1'b0, 2};

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_idx    = 6'd0;
    req_double = 1'b0;
    rsp_ready  = 1'b0;

    // Reset state while rst is held low.
    #3;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_value", {16'd0, rsp_value}, 32'd0);
    check("rst_rsp_ovf", {31'd0, rsp_overflow}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i].idx, vecs[i].dbl, vecs[i].val, vecs[i].ovf, vecs[i].lat);
    end

    // Backpressure in DONE with ignored request pulses.
    @(negedge clk);
    req_valid = 1'b1;
    req_idx   = 6'd5;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (!rsp_valid && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("bp_latency", cnt, 32'd5);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = i[0];
      req_idx   = 6'd3;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_value !== 16'd5 || rsp_overflow !== 1'b0 ||
          req_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
    end
    req_valid = 1'b0;
    check("bp_hold_stable", {31'd0, bad}, 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
    check("bp_busy_after", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("bp_no_queued_req", {31'd0, busy}, 32'd0);

    // Reset in the middle of a calculation.
    req_valid = 1'b1;
    req_idx   = 6'd20;
    req_double = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("mid_no_response", {31'd0, bad}, 32'd0);
    run_vec(6'd20, 1'b0, 16'd6765, 1'b0, 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_term_controller.md
Name: fib_term_controller

Overview:
- Request/response sequencer wrapped around a Fibonacci datapath (F(0)=0, F(1)=1).
- Accepts a term index over a valid/ready handshake and steps the internal (a,b) = (F(k),F(k+1)) register pair, either one term per cycle (single rate) or two terms per cycle (double rate).
- Returns F(idx) mod 2^WIDTH with a sticky overflow flag.
- Lets several upstream users share one generator without free-running it.

Parameters:
- WIDTH, 16, result/datapath width in bits.
- IDX_W, 6, width of the requested term index (max idx = 2^IDX_W-1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset: 0 resets immediately, release is synchronous to clk.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_idx  input  IDX_W  requested term index.
- req_double  input  1  1 = double-rate stepping, 0 = single-rate.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_value  output  WIDTH  F(idx) mod 2^WIDTH.
- rsp_overflow  output  1  true F(idx) >= 2^WIDTH.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; a=0, b=1, remaining=0, mode=0.
  - ovf_a=ovf_b=0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_value=0, rsp_overflow=0, busy=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: load a=0, b=1, ovf_a=ovf_b=0, remaining=req_idx, mode=req_double.
  - Go to CALC if req_idx!=0, else DONE.
  - req_idx and req_double are sampled only at the accepting edge.
- CALC single step (mode=0, or mode=1 with remaining==1):
  - a<=b, b<=a+b (mod 2^WIDTH), remaining-=1.
- CALC double step (mode=1, remaining>=2):
  - a<=a+b, b<=a+2b (mod 2^WIDTH), remaining-=2.
- CALC exit: the step that makes remaining reach 0 moves to DONE on the same edge.
- Overflow tracking (sticky):
  - Single step: ovf_a<=ovf_b; ovf_b<=ovf_a|ovf_b|carry(a+b).
  - Double step: ovf_a<=ovf_a|ovf_b|carry(a+b); ovf_b<=ovf_a|ovf_b|(a+2b computed in WIDTH+2 bits has nonzero bits above WIDTH-1).
- DONE:
  - rsp_valid=1, rsp_value=a, rsp_overflow=ovf_a.
  - Values are held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: go to IDLE. req_ready rises the following cycle, so there is no same-cycle accept after a response.
- Latency:
  - rsp_valid asserts S edges after the accepting edge, where S = idx (single) or ceil(idx/2) (double).
  - idx=0: rsp_valid is high in the cycle immediately after acceptance.
- req_ready=0 throughout CALC and DONE; requests presented then are ignored (not queued).
- busy=1 in CALC and DONE.
- Mid-operation reset: rst=0 at any time aborts the computation and forces reset values within the same cycle. No response is produced for the aborted request.
- Max idx with WIDTH=16: F(24)=46368 fits; F(25) and above set rsp_overflow=1.

Test Plan:
- Reset release, req_idx=10, req_double=0 -> rsp_valid 10 edges after accept, rsp_value=55, rsp_overflow=0; req_ready=0 and busy=1 throughout.
- req_idx=10, req_double=1 -> rsp_value=55 after 5 edges. Then req_idx=7, req_double=1 -> 3 double steps plus 1 single step, 4 edges, rsp_value=13.
- req_idx=0 -> rsp_value=0 in the cycle after accept. req_idx=1 -> rsp_value=1 after 1 edge (both modes).
- req_idx=24 single -> 46368, overflow=0. req_idx=25 single and double -> 9489, overflow=1. req_idx=63 -> overflow=1 in both modes with identical rsp_value.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_value and rsp_overflow stable, req_valid pulses ignored. rsp_ready=1 -> IDLE, req_ready=1 the next cycle.
- Drive rst=0 for 1 cycle mid-CALC (idx=20, after 6 steps) -> outputs reset asynchronously, no rsp_valid. A new request with idx=20 -> 6765.
